// File: rtl/mem_access_pkg.sv
// Shared defaults, FSM state type and latched-request layout for the data-memory initiator.
package mem_access_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_RD_LAT = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD      = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RSP     = 3'd4
  } mem_ctrl_state_t;

  // Field widths follow the package defaults; the controller is built at these widths.
  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// CPU data-memory initiator: single load/store over valid/ready, drives a 32x8 sync memory.
// Latency: store 1 cycle accept->rsp_valid, load 2+RD_LAT-1; MEM_ACCESS_CTRL_WR_VERIFY_EN adds a read-back on stores.
// Backpressure: req_ready only in IDLE; rsp_valid is a single pulse with no response backpressure.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  mem_ctrl_state_t  state;
  mem_req_t         req_q;
  logic [CNT_W-1:0] lat_cnt;
  logic             accept;
  logic             rd_done;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign rd_done   = (state == ST_RD_WAIT) && (lat_cnt == '0);

  // The latched request doubles as the memory address/data registers; wdata is only
  // reloaded on stores so mem_din keeps the last written value across loads.
  assign mem_add = req_q.addr;
  assign mem_din = req_q.wdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      lat_cnt   <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_q.we   <= req_we;
            req_q.addr <= req_addr;
            if (req_we) begin
              req_q.wdata <= req_wdata;
              mem_wr      <= 1'b1;
              state       <= ST_WR;
            end else begin
              mem_rd <= 1'b1;
              state  <= ST_RD;
            end
          end
        end
        ST_WR: begin
`ifdef MEM_ACCESS_CTRL_WR_VERIFY_EN
          mem_rd <= 1'b1;
          state  <= ST_RD;
`else
          rsp_valid <= 1'b1;
          state     <= ST_RSP;
`endif
        end
        ST_RD: begin
          lat_cnt <= CNT_W'(RD_LAT - 1);
          state   <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (rd_done) begin
            rsp_valid <= 1'b1;
            state     <= ST_RSP;
            // Verify read-backs of a store must not disturb the last load value.
            if (!req_q.we)
              rsp_rdata <= mem_dout;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        ST_RSP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_ACCESS_CTRL_WR_VERIFY_EN
  logic rsp_err_q;

  always_ff @(posedge clk) begin
    if (!rst)
      rsp_err_q <= 1'b0;
    else
      rsp_err_q <= rd_done && req_q.we && (mem_dout != req_q.wdata);
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  a_strobe_exclusive: assert property (@(posedge clk) disable iff (!rst) !(mem_rd && mem_wr));

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a 32x8 registered-output memory model.
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_CTRL_WR_VERIFY_EN
  localparam int ST_LAT = 3;
  localparam int ST_RDS = 1;
`else
  localparam int ST_LAT = 1;
  localparam int ST_RDS = 0;
`endif
  localparam int LD_LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_we = 1'b0;
  logic [4:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, rsp_valid, rsp_err, mem_rd, mem_wr;
  logic [7:0] rsp_rdata, mem_din;
  logic [7:0] mem_dout = '0;
  logic [4:0] mem_add;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_add(mem_add), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Memory device: write on mem_wr, registered read on mem_rd; corrupt forces read data.
  logic [7:0] dev_mem [32];
  logic       corrupt = 1'b0;
  always @(posedge clk) begin
    if (mem_wr) dev_mem[mem_add] <= mem_din;
    if (mem_rd) mem_dout <= corrupt ? 8'h32 : dev_mem[mem_add];
  end

  // Strobe monitor: running totals and last strobe address/data.
  int         wr_tot = 0, rd_tot = 0, overlap_cnt = 0;
  logic [4:0] wr_add = '0, rd_add = '0;
  logic [7:0] wr_din = '0;
  always @(negedge clk) begin
    if (rst) begin
      if (mem_wr) begin wr_tot++; wr_add = mem_add; wr_din = mem_din; end
      if (mem_rd) begin rd_tot++; rd_add = mem_add; end
      if (mem_wr && mem_rd) overlap_cnt++;
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s/%s: got 0x%0h, want 0x%0h", tag, what, act, exp);
    end
  endtask

  // Reference model: flat memory plus the last completed load value.
  logic [7:0] ref_mem [32];
  logic [7:0] ref_last = '0;
  function automatic logic [7:0] ref_apply(input logic we, input logic [4:0] a, input logic [7:0] d);
    if (we) ref_mem[a] = d;
    else    ref_last = ref_mem[a];
    return ref_last;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic run_op(input string tag, input logic we, input logic [4:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input int exp_lat, input logic exp_err);
    int n, lat, w0, r0;
    logic [7:0] rd;
    logic err;
    n = 0;
    while (!req_ready && n < 20) begin cyc(); n++; end
    w0 = wr_tot; r0 = rd_tot;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    cyc();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin cyc(); lat++; end
    rd = rsp_rdata; err = rsp_err;
    chk(tag, "latency", lat, exp_lat);
    chk(tag, "rdata", rd, exp_rd);
    chk(tag, "err", err, exp_err);
    chk(tag, "wr_strobes", wr_tot - w0, we ? 1 : 0);
    chk(tag, "rd_strobes", rd_tot - r0, we ? ST_RDS : 1);
    if (we) begin
      chk(tag, "wr_add", wr_add, a);
      chk(tag, "wr_din", wr_din, d);
    end else begin
      chk(tag, "rd_add", rd_add, a);
    end
    cyc();
    chk(tag, "pulse_end", rsp_valid, 0);
  endtask

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] e;
    logic       we;
    logic [4:0] a;
    logic [7:0] d;
    logic       b_we [4];
    logic [4:0] b_a  [4];
    logic [7:0] b_d  [4];
    logic [7:0] exp_q [$];
    int idx, nrsp, n, w0, r0;

    vecs[0] = '{1'b1, 5'h0A, 8'h5C, 8'h00, ST_LAT};
    vecs[1] = '{1'b1, 5'h1F, 8'hA7, 8'h00, ST_LAT};
    vecs[2] = '{1'b0, 5'h1F, 8'h00, 8'hA7, LD_LAT};
    vecs[3] = '{1'b0, 5'h0A, 8'h00, 8'h5C, LD_LAT};
    vecs[4] = '{1'b1, 5'h00, 8'hFF, 8'h5C, ST_LAT};
    vecs[5] = '{1'b0, 5'h00, 8'h00, 8'hFF, LD_LAT};

    // Reset held 3 cycles with a request pending.
    rst = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 5'h0A; req_wdata = 8'h5C;
    repeat (3) begin
      cyc();
      chk("reset", "outputs", {mem_rd, mem_wr, mem_add, mem_din, rsp_valid, rsp_rdata, rsp_err}, 0);
    end
    rst = 1'b1; req_valid = 1'b0;
    chk("reset", "ready", req_ready, 1);
    w0 = wr_tot; r0 = rd_tot;
    cyc();
    chk("reset", "no_strobe", (wr_tot - w0) + (rd_tot - r0), 0);

    for (int i = 0; i < 6; i++) begin
      void'(ref_apply(vecs[i].we, vecs[i].addr, vecs[i].wdata));
      run_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_lat, 1'b0);
    end

    // Back-to-back with req_valid held high.
    b_we = '{1'b1, 1'b0, 1'b1, 1'b0};
    b_a  = '{5'h03, 5'h03, 5'h04, 5'h04};
    b_d  = '{8'h11, 8'h00, 8'h22, 8'h00};
    w0 = wr_tot; r0 = rd_tot; idx = 0; nrsp = 0; n = 0;
    while (nrsp < 4 && n < 100) begin
      if (req_ready && idx < 4) begin
        req_valid = 1'b1; req_we = b_we[idx]; req_addr = b_a[idx]; req_wdata = b_d[idx];
        exp_q.push_back(ref_apply(b_we[idx], b_a[idx], b_d[idx]));
        idx++;
      end
      cyc(); n++;
      if (rsp_valid) begin
        chk($sformatf("b2b%0d", nrsp), "rdata", rsp_rdata, exp_q.pop_front());
        chk($sformatf("b2b%0d", nrsp), "err", rsp_err, 0);
        nrsp++;
      end
    end
    req_valid = 1'b0;
    chk("b2b", "responses", nrsp, 4);
    repeat (3) begin
      cyc();
      chk("b2b", "no_extra_rsp", rsp_valid, 0);
    end
    chk("b2b", "wr_strobes", wr_tot - w0, 2);
    chk("b2b", "rd_strobes", rd_tot - r0, 2 + 2 * ST_RDS);
    chk("b2b", "no_overlap", overlap_cnt, 0);

    // Reset during RD_WAIT of a load.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'h1F;
    cyc();
    req_valid = 1'b0;
    chk("midrst", "rd_strobe", mem_rd, 1);
    cyc();
    rst = 1'b0;
    cyc();
    chk("midrst", "rsp_valid", rsp_valid, 0);
    chk("midrst", "idle", req_ready, 1);
    chk("midrst", "rdata", rsp_rdata, 0);
    chk("midrst", "strobes", {mem_rd, mem_wr}, 0);
    rst = 1'b1;
    n = 0;
    repeat (4) begin cyc(); if (rsp_valid) n++; end
    chk("midrst", "no_rsp", n, 0);
    ref_last = '0;

    // Randomized: fill every address, then mixed traffic.
    for (int i = 0; i < 32; i++) begin
      a = 5'(i); d = 8'($urandom);
      e = ref_apply(1'b1, a, d);
      run_op("fill", 1'b1, a, d, e, ST_LAT, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1)); a = 5'($urandom); d = 8'($urandom);
      e = ref_apply(we, a, d);
      run_op($sformatf("rnd%0d", i), we, a, d, e, we ? ST_LAT : LD_LAT, 1'b0);
      repeat ($urandom_range(0, 2)) cyc();
    end

`ifdef MEM_ACCESS_CTRL_WR_VERIFY_EN
    corrupt = 1'b1;
    e = ref_apply(1'b1, 5'h07, 8'h33);
    run_op("vfy_bad", 1'b1, 5'h07, 8'h33, e, ST_LAT, 1'b1);
    corrupt = 1'b0;
    e = ref_apply(1'b1, 5'h07, 8'h33);
    run_op("vfy_ok", 1'b1, 5'h07, 8'h33, e, ST_LAT, 1'b0);
`endif

    chk("final", "no_overlap", overlap_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
